// File: rtl/led_shift_pattern_gen.sv
// Rotating LED pattern generator: a prescaler paces steps, and each step
// rotates the pattern right, rotates it left, bounces it or holds it, per mode.
module led_shift_pattern_gen #(
  parameter int LED_W = 4,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [LED_W-1:0] load_pattern,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             wrap,
  output logic             dir
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [LED_W-1:0] LED_RST = {1'b1, {(LED_W-1){1'b0}}};

  typedef enum logic [0:0] {
    GO_R = 1'b0,
    GO_L = 1'b1
  } state_t;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] base_q, base_d;
  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic             tick_s;
  logic [LED_W-1:0] rotr_s, rotl_s;

  assign rotr_s = {led_q[0], led_q[LED_W-1:1]};
  assign rotl_s = {led_q[LED_W-2:0], led_q[LED_W-1]};
  assign tick_s = en && (cnt_q == CNT_MAX);

  // Next-state: load beats tick; hold mode lets the prescaler run but never steps.
  always_comb begin
    cnt_d   = cnt_q;
    led_d   = led_q;
    base_d  = base_q;
    state_d = state_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (en) begin
      cnt_d = tick_s ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (load) begin
      led_d   = load_pattern;
      base_d  = load_pattern;
      cnt_d   = '0;
      state_d = GO_R;
    end else if (tick_s) begin
      case (mode)
        2'b00: begin
          led_d   = rotr_s;
          dir_d   = 1'b0;
          state_d = GO_R;
        end
        2'b01: begin
          led_d   = rotl_s;
          dir_d   = 1'b1;
          state_d = GO_L;
        end
        2'b10: begin
          if (state_q == GO_R) begin
            if (led_q[0]) begin
              led_d   = rotl_s;
              state_d = GO_L;
              dir_d   = 1'b1;
            end else begin
              led_d = rotr_s;
              dir_d = 1'b0;
            end
          end else begin
            if (led_q[LED_W-1]) begin
              led_d   = rotr_s;
              state_d = GO_R;
              dir_d   = 1'b0;
            end else begin
              led_d = rotl_s;
              dir_d = 1'b1;
            end
          end
        end
        default: begin
          led_d   = led_q;
          dir_d   = dir_q;
          state_d = state_q;
        end
      endcase
      step_d = (mode != 2'b11);
      wrap_d = (mode != 2'b11) && (led_d == base_q);
    end else begin
      step_d = 1'b0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      led_q   <= LED_RST;
      base_q  <= LED_RST;
      state_q <= GO_R;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      base_q  <= base_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_led_shift_pattern_gen.sv
// Bench for led_shift_pattern_gen (LED_W=4, DIV=4): directed vector table
// followed by randomized traffic against a pattern-level reference model.
module tb_led_shift_pattern_gen;

  localparam int W   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_pattern = '0;
  logic [W-1:0] led;
  logic         step, wrap, dir;

  int n_checks = 0;
  int n_fail   = 0;

  led_shift_pattern_gen #(.LED_W(W), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_pattern(load_pattern), .led(led), .step(step), .wrap(wrap), .dir(dir)
  );

  always #5 clk = ~clk;

  // Reference model state: pattern as a number, travel direction as a flag.
  int m_led, m_base, m_cnt;
  bit m_left, m_dir, m_step, m_wrap, m_valid = 1'b0;

  function automatic int rot_right(int x);
    return ((x >> 1) | ((x & 1) << (W - 1))) & ((1 << W) - 1);
  endfunction

  function automatic int rot_left(int x);
    return ((x << 1) | (x >> (W - 1))) & ((1 << W) - 1);
  endfunction

  task automatic model_update();
    bit tick;
    if (rst) begin
      m_led = 1 << (W - 1); m_base = m_led; m_cnt = 0;
      m_left = 1'b0; m_dir = 1'b0; m_step = 1'b0; m_wrap = 1'b0;
      m_valid = 1'b1;
    end else if (load) begin
      m_led = int'(load_pattern); m_base = m_led; m_cnt = 0;
      m_left = 1'b0; m_step = 1'b0; m_wrap = 1'b0;
    end else begin
      tick = en && (m_cnt == DIV - 1);
      if (en) m_cnt = (m_cnt + 1) % DIV;
      m_step = 1'b0; m_wrap = 1'b0;
      if (tick && mode != 2'b11) begin
        if (mode == 2'b00) m_left = 1'b0;
        else if (mode == 2'b01) m_left = 1'b1;
        else if (!m_left && (m_led & 1) != 0) m_left = 1'b1;
        else if (m_left && (m_led & (1 << (W - 1))) != 0) m_left = 1'b0;
        m_led  = m_left ? rot_left(m_led) : rot_right(m_led);
        m_dir  = m_left;
        m_step = 1'b1;
        m_wrap = (m_led == m_base);
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: inputs already set; model follows the edge, outputs sampled 1 time unit later.
  task automatic run_cycle();
    @(posedge clk);
    model_update();
    #1;
    if (m_valid) begin
      chk("model_led",  32'(led),  32'(m_led));
      chk("model_step", 32'(step), 32'(m_step));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
      chk("model_dir",  32'(dir),  32'(m_dir));
    end
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] pat;
    int           ncyc;
    logic [W-1:0] e_led;
    logic         e_step;
    logic         e_wrap;
    logic         e_dir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(logic r, logic e, logic [1:0] m, logic l, logic [W-1:0] p, int n,
                     logic [W-1:0] el, logic es, logic ew, logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.load = l; v.pat = p; v.ncyc = n;
    v.e_led = el; v.e_step = es; v.e_wrap = ew; v.e_dir = ed;
    vecs.push_back(v);
  endtask

  initial begin
    // Rotate right from reset
    add(1, 0, 2'b00, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 3, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 1, 4'b0100, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 1, 4'b0100, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 3, 4'b0010, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b0001, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b1000, 1, 1, 0);
    add(0, 1, 2'b00, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    // Rotate left from reset
    add(1, 0, 2'b01, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b01, 0, 4'h0, 4, 4'b0001, 1, 0, 1);
    add(0, 1, 2'b01, 0, 4'h0, 4, 4'b0010, 1, 0, 1);
    add(0, 1, 2'b01, 0, 4'h0, 4, 4'b0100, 1, 0, 1);
    add(0, 1, 2'b01, 0, 4'h0, 4, 4'b1000, 1, 1, 1);
    // Bounce from reset
    add(1, 0, 2'b10, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b0100, 1, 0, 0);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b0010, 1, 0, 0);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b0001, 1, 0, 0);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b0010, 1, 0, 1);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b0100, 1, 0, 1);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b1000, 1, 1, 1);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b0100, 1, 0, 0);
    // Enable freeze at cnt = 2
    add(1, 0, 2'b00, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 2, 4'b1000, 0, 0, 0);
    add(0, 0, 2'b00, 0, 4'h0, 10, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 1, 4'b0100, 1, 0, 0);
    // Load colliding with a tick, then rotate right
    add(1, 0, 2'b00, 0, 4'h0, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 3, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b00, 1, 4'b0110, 1, 4'b0110, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b0011, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b1001, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b1100, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b0110, 1, 1, 0);
    // Reset together with load and tick, then hold
    add(0, 1, 2'b00, 0, 4'h0, 3, 4'b0110, 0, 0, 0);
    add(1, 1, 2'b00, 1, 4'b0101, 1, 4'b1000, 0, 0, 0);
    add(0, 1, 2'b11, 0, 4'h0, 12, 4'b1000, 0, 0, 0);
    // All-ones bounce and all-zero rotate
    add(0, 1, 2'b10, 1, 4'b1111, 1, 4'b1111, 0, 0, 0);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b1111, 1, 1, 1);
    add(0, 1, 2'b10, 0, 4'h0, 4, 4'b1111, 1, 1, 0);
    add(0, 1, 2'b00, 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b0000, 1, 1, 0);
    add(0, 1, 2'b00, 0, 4'h0, 4, 4'b0000, 1, 1, 0);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      load = vecs[i].load; load_pattern = vecs[i].pat;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        run_cycle();
      end
      chk($sformatf("vec%0d_led", i),  32'(led),  32'(vecs[i].e_led));
      chk($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].e_step));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
      chk($sformatf("vec%0d_dir", i),  32'(dir),  32'(vecs[i].e_dir));
    end

    // Randomized traffic: occasional reset/load, mostly enabled, sticky modes.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 249) == 0);
      load = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       load_pattern = 4'b0000;
        1:       load_pattern = 4'b1111;
        default: load_pattern = 4'($urandom);
      endcase
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
